vga_timing_gen: RTL

//  Parametrised VGA sync/timing generator; successor to the fixed 640x480 vga_sync.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen_tick_div.sv | 40 ++++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, axis-total helper and
// sync polarity constants, reused by the timing generator and pixel-generation blocks.
package vga_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_CW        = 10;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Total period of one axis (line or frame) including all blanking segments.
    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    // Drive level of a sync line given whether it is asserted and its polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus between the VGA timing generator (master) and pixel/RGB logic (slave).
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic          p_tick;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_tick_div.sv
// Pixel tick divider: counts CLK_DIV clk cycles while enabled and flags the
// cycle on which the timing counters must advance.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic advance_o
);
    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Next divider count: wraps at CLK_DIV-1, frozen while disabled.
    always_comb begin
        div_d = div_q;
        if (!en_i) begin
            div_d = div_q;
        end else if (div_q == DIV_LAST) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= {DW{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    assign advance_o = en_i && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator: h/v position counters on a divided pixel
// tick, with registered sync, video_on and line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter bit HSYNC_POL = POL_ACTIVE_LOW,
    parameter bit VSYNC_POL = POL_ACTIVE_LOW,
    parameter int CW        = DEF_CW
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS     = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS     = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST  = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_cw_too_small
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic          advance_s;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          video_q, video_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          p_tick_q;
    logic          line_q;
    logic          frame_q;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (bus.en),
        .advance_o (advance_s)
    );

    // Next counter position; y only moves on the x wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = {CW{1'b0}};
            if (y_q == V_LAST) begin
                y_d = {CW{1'b0}};
            end else begin
                y_d = y_q + CW'(1);
            end
        end else begin
            x_d = x_q + CW'(1);
            y_d = y_q;
        end
    end

    // Decode video window and sync levels from the next position so they register with it.
    always_comb begin
        video_d = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d = sync_level((x_d >= HS_FIRST) && (x_d <= HS_LAST), HSYNC_POL);
        vsync_d = sync_level((y_d >= VS_FIRST) && (y_d <= VS_LAST), VSYNC_POL);
    end

    // Position and output registers; strobes are single-cycle on the advancing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            video_q  <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            p_tick_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else if (advance_s) begin
            x_q      <= x_d;
            y_q      <= y_d;
            video_q  <= video_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            p_tick_q <= 1'b1;
            line_q   <= (x_d == {CW{1'b0}});
            frame_q  <= (x_d == {CW{1'b0}}) && (y_d == {CW{1'b0}});
        end else begin
            p_tick_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end
    end

    assign bus.p_tick      = p_tick_q;
    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
    assign bus.video_on    = video_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.line_start  = line_q;
    assign bus.frame_start = frame_q;

endmodule
